// File: rtl/tag_free_list.sv
// Circular pool of free rename tags for dispatch; preloaded with every tag at reset,
// head tag presented combinationally, CDB broadcasts return tags to the tail.
module tag_free_list #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_valid,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic [TAG_W:0]   free_count,
    output logic             full,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_W:0]   free_count_q, free_count_d;
    logic             full_q, full_d;
    logic             overflow_err_q, overflow_err_d;
    logic             underflow_err_q, underflow_err_d;
    logic             empty, at_full, pop, push;

    // Push eligibility uses pre-edge state, so a full pool drops a release even if it pops.
    always_comb begin
        empty   = (free_count_q == '0);
        at_full = (free_count_q == FULL_CNT);
        pop     = alloc_req & ~empty;
        push    = cdb_valid & ~at_full;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = cdb_tag;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        free_count_d = free_count_q;
        if (push && !pop) begin
            free_count_d = free_count_q + 1'b1;
        end else if (pop && !push) begin
            free_count_d = free_count_q - 1'b1;
        end
        full_d = (free_count_d == FULL_CNT);

        overflow_err_d  = overflow_err_q  | (cdb_valid & at_full);
        underflow_err_d = underflow_err_q | (alloc_req & empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_W'(i);
            end
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            free_count_q    <= FULL_CNT;
            full_q          <= 1'b1;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            mem_q           <= mem_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            free_count_q    <= free_count_d;
            full_q          <= full_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign alloc_tag     = mem_q[rd_ptr_q];
    assign alloc_valid   = (free_count_q != '0);
    assign free_count    = free_count_q;
    assign full          = full_q;
    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_tag_free_list.sv
// Directed bench for tag_free_list: a queue of expected free tags is the scoreboard,
// tags are pushed when a release is driven and popped/compared when dispatch allocates.
module tb_tag_free_list;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_req = 1'b0;
    logic       cdb_valid = 1'b0;
    logic [5:0] cdb_tag = '0;
    logic [5:0] alloc_tag;
    logic       alloc_valid;
    logic [6:0] free_count;
    logic       full;
    logic       overflow_err;
    logic       underflow_err;

    int         errors = 0;
    int         checks = 0;
    logic [5:0] sbq[$];
    logic [5:0] popped[$];
    logic       exp_ovf;
    logic       exp_unf;

    tag_free_list #(.TAG_W(6), .DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_tag    (alloc_tag),
        .alloc_valid  (alloc_valid),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .free_count   (free_count),
        .full         (full),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("alloc_valid", alloc_valid, sbq.size() != 0);
        checkOutput("free_count", free_count, sbq.size());
        checkOutput("full", full, sbq.size() == 64);
        checkOutput("overflow_err", overflow_err, exp_ovf);
        checkOutput("underflow_err", underflow_err, exp_unf);
        if (sbq.size() != 0) checkOutput("alloc_tag", alloc_tag, sbq[0]);
    endtask

    task automatic modelReset();
        sbq.delete();
        for (int i = 0; i < 64; i++) sbq.push_back(6'(i));
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    // Called just after a rising edge; drives one cycle, scores it, advances to the next edge.
    task automatic applyStimulus(input logic req, input logic cv, input logic [5:0] tag);
        bit can_pop;
        bit can_push;
        bit dup;
        alloc_req = req;
        cdb_valid = cv;
        cdb_tag   = tag;
        checkState();
        can_pop  = sbq.size() != 0;
        can_push = sbq.size() != 64;
        if (req && !can_pop) exp_unf = 1'b1;
        if (cv && !can_push) exp_ovf = 1'b1;
        if (req && can_pop) void'(sbq.pop_front());
        if (cv && can_push) begin
            dup = 1'b0;
            foreach (sbq[k]) if (sbq[k] == tag) dup = 1'b1;
            assert (!dup) else $fatal(1, "[TB] FAIL dup_release: tag=%0d already free", tag);
            sbq.push_back(tag);
        end
        @(posedge clk);
        #1;
        alloc_req = 1'b0;
        cdb_valid = 1'b0;
    endtask

    // Reset is asserted between clock edges; its effect must be visible before any edge.
    task automatic resetDut();
        alloc_req = 1'b0;
        cdb_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_free_count", free_count, 64);
        checkOutput("rst_alloc_tag", alloc_tag, 0);
        checkOutput("rst_ovf", overflow_err, 0);
        checkOutput("rst_unf", underflow_err, 0);
        checkState();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        modelReset();
        @(posedge clk);
        #1;
        resetDut();

        $display("[TB] 64 back-to-back allocations");
        for (int i = 0; i < 64; i++) begin
            checkOutput("seq_tag", alloc_tag, i);
            applyStimulus(1'b1, 1'b0, 6'd0);
        end
        checkOutput("drained_valid", alloc_valid, 0);
        checkOutput("drained_count", free_count, 0);
        checkOutput("drained_unf", underflow_err, 0);

        $display("[TB] release 5, 9, 2 into empty pool");
        applyStimulus(1'b0, 1'b1, 6'd5);
        checkOutput("count_after_5", free_count, 1);
        applyStimulus(1'b0, 1'b1, 6'd9);
        checkOutput("count_after_9", free_count, 2);
        applyStimulus(1'b0, 1'b1, 6'd2);
        checkOutput("count_after_2", free_count, 3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 6'd0);

        $display("[TB] simultaneous alloc and release while empty");
        applyStimulus(1'b1, 1'b1, 6'd17);
        checkOutput("bypass_unf", underflow_err, 1);
        checkOutput("bypass_valid", alloc_valid, 1);
        checkOutput("bypass_tag", alloc_tag, 17);
        checkOutput("bypass_count", free_count, 1);

        $display("[TB] steady pop plus delayed release at free_count=10");
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 6'(i));
        popped.delete();
        for (int i = 0; i < 60; i++) begin
            logic [5:0] rel;
            popped.push_back(sbq[0]);
            rel = (i < 3) ? 6'(20 + i) : popped[i-3];
            checkOutput("steady_count", free_count, 10);
            applyStimulus(1'b1, 1'b1, rel);
        end
        checkOutput("steady_count_end", free_count, 10);
        for (int i = 57; i < 60; i++) applyStimulus(1'b0, 1'b1, popped[i]);
        checkOutput("steady_refill", free_count, 13);

        $display("[TB] release while full");
        resetDut();
        applyStimulus(1'b0, 1'b1, 6'd40);
        checkOutput("ovf_set", overflow_err, 1);
        checkOutput("ovf_count", free_count, 64);
        checkOutput("ovf_next_tag", alloc_tag, 0);
        applyStimulus(1'b1, 1'b0, 6'd0);
        resetDut();
        applyStimulus(1'b1, 1'b1, 6'd41);
        checkOutput("full_pop_count", free_count, 63);
        checkOutput("full_pop_tag", alloc_tag, 1);

        $display("[TB] async reset with 30 tags outstanding");
        resetDut();
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 6'd0);
        checkOutput("pre_reset_count", free_count, 34);
        resetDut();
        for (int i = 0; i < 3; i++) begin
            checkOutput("reissue_tag", alloc_tag, i);
            applyStimulus(1'b1, 1'b0, 6'd0);
        end
        checkState();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
